// File: rtl/alu_op_sequencer_pkg.sv
// Shared definitions for the ALU operation sequencer: widths, opcode map and
// the sequencer state encoding.
package alu_op_sequencer_pkg;

    localparam int DATA_W   = 4;
    localparam int NUM_REGS = 4;
    localparam int ADDR_W   = 2;
    localparam int NUM_OPS  = 13;

    localparam logic [3:0] OP_WR   = 4'd0;
    localparam logic [3:0] OP_RD   = 4'd1;
    localparam logic [3:0] OP_CPY  = 4'd2;
    localparam logic [3:0] OP_NOT  = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_OR   = 4'd5;
    localparam logic [3:0] OP_XOR  = 4'd6;
    localparam logic [3:0] OP_NAND = 4'd7;
    localparam logic [3:0] OP_NOR  = 4'd8;
    localparam logic [3:0] OP_ADD  = 4'd9;
    localparam logic [3:0] OP_SUB  = 4'd10;
    localparam logic [3:0] OP_LSF  = 4'd11;
    localparam logic [3:0] OP_RSF  = 4'd12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WB    = 2'd2
    } state_t;

    function automatic logic is_legal(input logic [3:0] op);
        return op <= OP_RSF;
    endfunction

endpackage

// File: rtl/alu_op_sequencer_decoder.sv
// Opcode to one-hot ALU enable decoder; enables are forced low unless the
// sequencer is in its issue cycle.
module alu_op_decoder
    import alu_op_sequencer_pkg::*;
(
    input  logic [3:0]         opcode,
    input  logic               issue,
    output logic [NUM_OPS-1:0] enables,
    output logic               is_illegal
);

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        enables    = '0;
        is_illegal = !is_legal(opcode);
        if (issue && !is_illegal)
            enables = NUM_OPS'(1) << opcode;
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Control stage for the 4-bit ALU: accepts an instruction, snapshots operands
// from a 4x4 register file, issues one ALU op and writes the result back.
module alu_op_sequencer
    import alu_op_sequencer_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [3:0]        opcode,
    input  logic [ADDR_W-1:0] dst,
    input  logic [ADDR_W-1:0] src,
    input  logic [DATA_W-1:0] imm,
    output logic              wr_en,
    output logic              read_en,
    output logic              copy_en,
    output logic              not_en,
    output logic              and_en,
    output logic              or_en,
    output logic              xor_en,
    output logic              nand_en,
    output logic              nor_en,
    output logic              add_en,
    output logic              sub_en,
    output logic              LSF_en,
    output logic              RSF_en,
    output logic [DATA_W-1:0] alu_rd1,
    output logic [DATA_W-1:0] alu_rd2,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_overflow,
    output logic              done,
    output logic [DATA_W-1:0] disp_data,
    output logic              ovf_flag,
    output logic              illegal
);

    state_t              state_q, state_d;
    logic [3:0]          op_q;
    logic [ADDR_W-1:0]   dst_q;
    logic [DATA_W-1:0]   opa_q, opb_q, res_q;
    logic                ovf_q;
    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic                issue, accept, op_illegal;
    logic [NUM_OPS-1:0]  enables;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (instr_valid) state_d = is_legal(opcode) ? ISSUE : WB;
            ISSUE:   state_d = WB;
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        instr_ready = (state_q == IDLE);
        issue       = (state_q == ISSUE);
        done        = (state_q == WB);
    end

    assign accept = instr_ready && instr_valid;

    alu_op_decoder u_decoder (
        .opcode     (op_q),
        .issue      (issue),
        .enables    (enables),
        .is_illegal (op_illegal)
    );

    // NOTE: the register file is cleared by reset because architectural
    // state must read as zero after reset, unlike a plain buffer memory.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q      <= '0;
            dst_q     <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            res_q     <= '0;
            ovf_q     <= 1'b0;
            disp_data <= '0;
            ovf_flag  <= 1'b0;
            illegal   <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            if (accept) begin
                op_q  <= opcode;
                dst_q <= dst;
                opa_q <= regs[dst];
                opb_q <= (opcode == OP_WR) ? imm : regs[src];
            end
            if (issue) begin
                res_q <= alu_result;
                ovf_q <= alu_overflow;
            end
            if (done) begin
                if (!op_illegal && op_q != OP_RD) regs[dst_q] <= res_q;
                if (op_q == OP_RD) disp_data <= res_q;
                ovf_flag <= ovf_q && (op_q == OP_ADD || op_q == OP_SUB);
                illegal  <= op_illegal;
            end
        end
    end

    assign alu_rd1 = opa_q;
    assign alu_rd2 = opb_q;

    assign wr_en   = enables[OP_WR];
    assign read_en = enables[OP_RD];
    assign copy_en = enables[OP_CPY];
    assign not_en  = enables[OP_NOT];
    assign and_en  = enables[OP_AND];
    assign or_en   = enables[OP_OR];
    assign xor_en  = enables[OP_XOR];
    assign nand_en = enables[OP_NAND];
    assign nor_en  = enables[OP_NOR];
    assign add_en  = enables[OP_ADD];
    assign sub_en  = enables[OP_SUB];
    assign LSF_en  = enables[OP_LSF];
    assign RSF_en  = enables[OP_RSF];

endmodule
